rx_byte_fifo: RTL and testbench

//  Byte FIFO between the UART receiver and the byte consumer (interface/command logic).

---
 rtl/rx_byte_fifo_pkg.sv | 12 +
 rtl/rx_byte_fifo_regfile.sv | 30 +++
 rtl/rx_byte_fifo.sv | 97 +++++++++
 tb/tb_rx_byte_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rx_byte_fifo_pkg.sv
// Shared widths for the UART receive path so the receiver, FIFO and consumer agree on
// the byte size and the default buffer depth.
package rx_byte_fifo_pkg;

    localparam int RX_NB_BITS    = 8;
    localparam int RX_DEPTH_LOG2 = 4;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/rx_byte_fifo_regfile.sv
// Storage array for rx_byte_fifo: one synchronous write port and one combinational
// read port so the FIFO head falls through without an extra cycle.
module rx_byte_fifo_regfile
    import rx_byte_fifo_pkg::*;
#(
    parameter int NB_BITS    = RX_NB_BITS,
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [NB_BITS-1:0]    wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [NB_BITS-1:0]    rdata
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);

    logic [NB_BITS-1:0] mem [DEPTH];

    // Contents are never reset; the FIFO's count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Byte FIFO between the UART receiver and the command consumer: strobe writes,
// first-word-fall-through pops, and a sticky flag for bytes dropped while full.
module rx_byte_fifo
    import rx_byte_fifo_pkg::*;
#(
    parameter int NB_BITS    = RX_NB_BITS,
    parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_BITS-1:0]    i_data,
    input  logic                  i_wr,
    input  logic                  i_rd,
    input  logic                  i_clr_ovf,
    output logic [NB_BITS-1:0]    o_data,
    output logic                  o_valid,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow
);

    localparam int                DEPTH      = fifo_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  ovf_reg;
    logic                  ovf_next;
    logic                  rd_eff;
    logic                  wr_acc;
    logic                  ovf_set;
    logic [NB_BITS-1:0]    head_data;

    assign o_valid = (count_reg != '0);
    assign o_full  = (count_reg == FULL_COUNT);
    assign o_count = count_reg;
    assign o_overflow = ovf_reg;

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign rd_eff  = i_rd && o_valid;
    assign wr_acc  = i_wr && (!o_full || rd_eff);
    assign ovf_set = i_wr && o_full && !rd_eff;

    rx_byte_fifo_regfile #(
        .NB_BITS    (NB_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regfile (
        .clk   (i_clk),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (i_data),
        .raddr (rd_ptr_reg),
        .rdata (head_data)
    );

    // Masking when empty keeps o_data at zero out of reset without resetting the array.
    assign o_data = o_valid ? head_data : '0;

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_eff})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        ovf_next = ovf_reg;
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_eff) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Randomized and directed bench for rx_byte_fifo; a queue-based reference tracks
// accepted bytes and a negedge monitor checks flags and popped data.
module tb_rx_byte_fifo;

    localparam int NB    = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [NB-1:0] i_data = '0;
    logic          i_wr = 1'b0;
    logic          i_rd = 1'b0;
    logic          i_clr_ovf = 1'b0;
    logic [NB-1:0] o_data;
    logic          o_valid;
    logic          o_full;
    logic [DL2:0]  o_count;
    logic          o_overflow;

    int errors = 0;
    int checks = 0;

    // Reference: bytes accepted but not yet popped, plus occupancy and sticky flag.
    logic [NB-1:0] exp_q [$];
    int            model_cnt = 0;
    bit            model_ovf = 1'b0;

    rx_byte_fifo #(.NB_BITS(NB), .DEPTH_LOG2(DL2)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_wr       (i_wr),
        .i_rd       (i_rd),
        .i_clr_ovf  (i_clr_ovf),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference update on each accepted edge, from the queue-occupancy rules.
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            exp_q.delete();
            model_cnt = 0;
            model_ovf = 1'b0;
        end else begin
            bit rd_ok;
            bit wr_ok;
            rd_ok = i_rd && (model_cnt > 0);
            wr_ok = i_wr && ((model_cnt < DEPTH) || rd_ok);
            if (i_wr && !wr_ok) model_ovf = 1'b1;
            else if (i_clr_ovf) model_ovf = 1'b0;
            if (wr_ok) exp_q.push_back(i_data);
            model_cnt = model_cnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        end
    end

    // Monitor: flags every cycle, data on each pop handshake.
    always @(negedge i_clk) begin
        if (i_rst) begin
            check("count", 32'(o_count), 32'(model_cnt));
            check("valid", 32'(o_valid), 32'(model_cnt > 0));
            check("full", 32'(o_full), 32'(model_cnt == DEPTH));
            check("overflow", 32'(o_overflow), 32'(model_ovf));
            if (o_valid && i_rd) begin
                if (exp_q.size() == 0) begin
                    check("pop_with_empty_model", 32'(o_valid), 32'd0);
                end else begin
                    $display("pop data=0x%02h expected=0x%02h count=%0d", o_data, exp_q[0], o_count);
                    check("pop_data", 32'(o_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one cycle of inputs starting just after a rising edge.
    task automatic step(input bit w, input logic [NB-1:0] d, input bit r, input bit c);
        i_wr = w; i_data = d; i_rd = r; i_clr_ovf = c;
        @(posedge i_clk);
        #1;
        i_wr = 1'b0; i_rd = 1'b0; i_clr_ovf = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (o_valid && guard < 64) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check("drain_empty", 32'(o_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_count", 32'(o_count), 32'd0);
        check("reset_data", 32'(o_data), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Async reset mid-stream with three bytes stored.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        check("pre_reset_count", 32'(o_count), 32'd3);
        #2 i_rst = 1'b0;
        #1;
        check("async_rst_count", 32'(o_count), 32'd0);
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_ovf", 32'(o_overflow), 32'd0);
        check("async_rst_data", 32'(o_data), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        step(1'b1, 8'h41, 1'b0, 1'b0);
        check("post_rst_data", 32'(o_data), 32'h41);
        check("post_rst_valid", 32'(o_valid), 32'd1);
        drain();

        // Three writes then three pops.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("three_count", 32'(o_count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("three_valid_after", 32'(o_valid), 32'd0);

        // Fill, overflow, drain, clear.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(o_full), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd16);
        drain();
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clear", 32'(o_overflow), 32'd0);

        // Full with simultaneous write and pop.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("full_rw_count", 32'(o_count), 32'd16);
        check("full_rw_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("full_rw_last", 32'(o_data), 32'h5A);
        drain();

        // Empty with simultaneous write and pop.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("empty_rw_count", 32'(o_count), 32'd1);
        check("empty_rw_data", 32'(o_data), 32'h77);
        drain();

        // Pointer wrap with interleaved write/pop pairs.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i + 1), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // Random traffic, including set/clear races on the overflow flag.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 19) == 0));
        end
        drain();
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
